// File: rtl/lcd_char_engine.sv
// HD44780 8-bit write engine: power-on wait, init sequence, random-access character writes and clear.
// Optional shadow-RAM write suppression is enabled by defining LCD_SHADOW_CACHE_EN.
module lcd_char_engine #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 16,
    parameter int unsigned T_POWER_US = 20000,
    parameter int unsigned T_SETUP_US = 1,
    parameter int unsigned T_EN_US    = 1,
    parameter int unsigned T_EXEC_US  = 50,
    parameter int unsigned T_CLEAR_US = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_clr,
    input  logic [1:0] req_row,
    input  logic [5:0] req_col,
    input  logic [7:0] req_char,
    output logic       init_done,
    output logic       err_range,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_on,
    output logic       lcd_blon
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;

    // Counter load value for an N-cycle state: floor(cycles), at least one cycle.
    function automatic logic [31:0] load_val(input int unsigned raw);
        return (raw == 0) ? 32'd0 : 32'(raw - 1);
    endfunction

    localparam logic [31:0] LD_POWER = load_val(CYC_PER_US * T_POWER_US);
    localparam logic [31:0] LD_SETUP = load_val(CYC_PER_US * T_SETUP_US);
    localparam logic [31:0] LD_EN    = load_val(CYC_PER_US * T_EN_US);
    localparam logic [31:0] LD_EXEC  = load_val(CYC_PER_US * T_EXEC_US);
    localparam logic [31:0] LD_CLEAR = load_val(CYC_PER_US * T_CLEAR_US);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_LOAD, IDLE, ADDR, SETUP, EN_HI, EXEC, DONE_OP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  init_idx_q, init_idx_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [7:0]  addr_cmd_q, addr_cmd_d;
    logic [1:0]  trk_row_q, trk_row_d;
    logic [5:0]  trk_col_q, trk_col_d;
    logic        trk_valid_q, trk_valid_d;
    logic [7:0]  lcd_data_d;
    logic        lcd_rs_d, lcd_en_d, req_ready_d, init_done_d, err_range_d;

    logic        accept;
    logic        in_range;
    logic        trk_hit;
    logic        shadow_hit;
    logic        col_last;
    logic [7:0]  ddram_addr;
    logic [7:0]  init_byte;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

    // Request decode: range check, cursor-tracker hit and DDRAM address.
    always_comb begin
        accept   = req_valid && req_ready;
        in_range = (32'(req_row) < ROWS) && (32'(req_col) < COLS);
        trk_hit  = trk_valid_q && (trk_row_q == req_row) && (trk_col_q == req_col);
        col_last = (32'(req_col) + 32'd1) >= COLS;
        ddram_addr = 8'(req_col);
        if (req_row[0]) ddram_addr = ddram_addr + 8'h40;
        if (req_row[1]) ddram_addr = ddram_addr + 8'(COLS);
    end

    always_comb begin
        case (init_idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

`ifdef LCD_SHADOW_CACHE_EN
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [7:0]       shadow_q [CELLS];
    logic [IDX_W-1:0] shadow_idx;

    assign shadow_idx = IDX_W'(32'(req_row) * COLS + 32'(req_col));
    assign shadow_hit = in_range && (shadow_q[shadow_idx] == req_char);

    // Mirror of displayed characters; blank is 0x20 after reset and clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CELLS; i++) shadow_q[i] <= 8'h20;
        end else if (accept && req_clr) begin
            for (int unsigned i = 0; i < CELLS; i++) shadow_q[i] <= 8'h20;
        end else if (accept && in_range && !shadow_hit) begin
            shadow_q[shadow_idx] <= req_char;
        end
    end
`else
    assign shadow_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= LD_POWER;
            init_idx_q  <= 2'd0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            addr_cmd_q  <= 8'h00;
            trk_row_q   <= 2'd0;
            trk_col_q   <= 6'd0;
            trk_valid_q <= 1'b0;
            lcd_data    <= 8'h00;
            lcd_rs      <= 1'b0;
            lcd_en      <= 1'b0;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            addr_cmd_q  <= addr_cmd_d;
            trk_row_q   <= trk_row_d;
            trk_col_q   <= trk_col_d;
            trk_valid_q <= trk_valid_d;
            lcd_data    <= lcd_data_d;
            lcd_rs      <= lcd_rs_d;
            lcd_en      <= lcd_en_d;
            req_ready   <= req_ready_d;
            init_done   <= init_done_d;
            err_range   <= err_range_d;
        end
    end

    // Next-state and registered-output logic; bus bytes only change while EN is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        addr_cmd_d  = addr_cmd_q;
        trk_row_d   = trk_row_q;
        trk_col_d   = trk_col_q;
        trk_valid_d = trk_valid_q;
        lcd_data_d  = lcd_data;
        lcd_rs_d    = lcd_rs;
        lcd_en_d    = 1'b0;
        req_ready_d = 1'b0;
        init_done_d = init_done;
        err_range_d = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == 32'd0) state_d = INIT_LOAD;
                else                cnt_d   = cnt_q - 32'd1;
            end
            INIT_LOAD: begin
                lcd_data_d = init_byte;
                lcd_rs_d   = 1'b0;
                cnt_d      = LD_SETUP;
                state_d    = SETUP;
            end
            IDLE: begin
                req_ready_d = init_done;
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (req_clr) begin
                        lcd_data_d  = 8'h01;
                        lcd_rs_d    = 1'b0;
                        pend_d      = 1'b0;
                        cnt_d       = LD_SETUP;
                        state_d     = SETUP;
                        trk_row_d   = 2'd0;
                        trk_col_d   = 6'd0;
                        trk_valid_d = 1'b1;
                    end else if (!in_range) begin
                        err_range_d = 1'b1;
                    end else if (!shadow_hit) begin
                        // Auto-increment does not follow the row map past the last column.
                        pend_data_d = req_char;
                        trk_row_d   = req_row;
                        trk_col_d   = req_col + 6'd1;
                        trk_valid_d = !col_last;
                        if (trk_hit) begin
                            lcd_data_d = req_char;
                            lcd_rs_d   = 1'b1;
                            pend_d     = 1'b0;
                            cnt_d      = LD_SETUP;
                            state_d    = SETUP;
                        end else begin
                            addr_cmd_d = 8'h80 | ddram_addr;
                            pend_d     = 1'b1;
                            state_d    = ADDR;
                        end
                    end
                end
            end
            ADDR: begin
                lcd_data_d = addr_cmd_q;
                lcd_rs_d   = 1'b0;
                cnt_d      = LD_SETUP;
                state_d    = SETUP;
            end
            SETUP: begin
                if (cnt_q == 32'd0) begin
                    lcd_en_d = 1'b1;
                    cnt_d    = LD_EN;
                    state_d  = EN_HI;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            EN_HI: begin
                if (cnt_q == 32'd0) begin
                    cnt_d   = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? LD_CLEAR : LD_EXEC;
                    state_d = EXEC;
                end else begin
                    lcd_en_d = 1'b1;
                    cnt_d    = cnt_q - 32'd1;
                end
            end
            EXEC: begin
                if (cnt_q == 32'd0) state_d = DONE_OP;
                else                cnt_d   = cnt_q - 32'd1;
            end
            DONE_OP: begin
                if (pend_q) begin
                    lcd_data_d = pend_data_q;
                    lcd_rs_d   = 1'b1;
                    pend_d     = 1'b0;
                    cnt_d      = LD_SETUP;
                    state_d    = SETUP;
                end else if (!init_done) begin
                    if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        req_ready_d = 1'b1;
                        trk_row_d   = 2'd0;
                        trk_col_d   = 6'd0;
                        trk_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = INIT_LOAD;
                    end
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

endmodule

// File: tb/tb_lcd_char_engine.sv
// Bench for lcd_char_engine: a 2x16 and a 4x20 instance, a directed vector table,
// and randomized requests checked against a request-level model of the display.
module tb_lcd_char_engine;

`ifdef LCD_SHADOW_CACHE_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    localparam int T_POWER = 100;
    localparam int T_SETUP = 1;
    localparam int T_EN    = 1;
    localparam int T_EXEC  = 5;
    localparam int T_CLEAR = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_ready, req_clr, init_done, err_range;
    logic [1:0]      lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon;
    logic [1:0][1:0] req_row;
    logic [1:0][5:0] req_col;
    logic [1:0][7:0] req_char, lcd_data;

    lcd_char_engine #(.CLK_HZ(1_000_000), .ROWS(2), .COLS(16), .T_POWER_US(T_POWER),
                      .T_SETUP_US(T_SETUP), .T_EN_US(T_EN), .T_EXEC_US(T_EXEC), .T_CLEAR_US(T_CLEAR)) u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_clr(req_clr[0]), .req_row(req_row[0]), .req_col(req_col[0]), .req_char(req_char[0]),
        .init_done(init_done[0]), .err_range(err_range[0]), .lcd_data(lcd_data[0]), .lcd_rs(lcd_rs[0]),
        .lcd_en(lcd_en[0]), .lcd_rw(lcd_rw[0]), .lcd_on(lcd_on[0]), .lcd_blon(lcd_blon[0]));

    lcd_char_engine #(.CLK_HZ(1_000_000), .ROWS(4), .COLS(20), .T_POWER_US(T_POWER),
                      .T_SETUP_US(T_SETUP), .T_EN_US(T_EN), .T_EXEC_US(T_EXEC), .T_CLEAR_US(T_CLEAR)) u1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_clr(req_clr[1]), .req_row(req_row[1]), .req_col(req_col[1]), .req_char(req_char[1]),
        .init_done(init_done[1]), .err_range(err_range[1]), .lcd_data(lcd_data[1]), .lcd_rs(lcd_rs[1]),
        .lcd_en(lcd_en[1]), .lcd_rw(lcd_rw[1]), .lcd_on(lcd_on[1]), .lcd_blon(lcd_blon[1]));

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            errors++;
            $display("FAIL %s: got %0d, required at least %0d", name, act, lo);
        end
    endtask

    // Bus monitor: EN rising edges captured as {rs,data}, plus timing/protocol watchers.
    int cyc = 0;
    int rel_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]      cap0[$];
    logic [8:0]      cap1[$];
    int              viol_stable = 0;
    int              viol_width  = 0;
    int              viol_ready  = 0;
    int              min_gap_clr[2]  = '{1000000, 1000000};
    int              min_gap_norm[2] = '{1000000, 1000000};
    int              first_en[2] = '{-1, -1};
    int              last_rise[2];
    int              en_run[2];
    bit              have_last[2];
    bit              last_clr[2];
    logic [1:0]      en_prev;
    logic [1:0]      rs_prev;
    logic [1:0][7:0] d_prev;

    always @(negedge clk) begin
        int gap;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                en_prev[i]   = 1'b0;
                have_last[i] = 1'b0;
                en_run[i]    = 0;
                first_en[i]  = -1;
            end else begin
                if (lcd_en[i] && (lcd_data[i] != d_prev[i] || lcd_rs[i] != rs_prev[i])) viol_stable++;
                if (req_ready[i] && !init_done[i]) viol_ready++;
                if (lcd_en[i]) en_run[i]++;
                else if (en_prev[i]) begin
                    if (en_run[i] != T_EN) viol_width++;
                    en_run[i] = 0;
                end
                if (lcd_en[i] && !en_prev[i]) begin
                    if (first_en[i] < 0) first_en[i] = cyc - rel_cyc;
                    if (have_last[i]) begin
                        gap = cyc - last_rise[i];
                        if (last_clr[i]) begin
                            if (gap < min_gap_clr[i]) min_gap_clr[i] = gap;
                        end else if (gap < min_gap_norm[i]) min_gap_norm[i] = gap;
                    end
                    have_last[i] = 1'b1;
                    last_rise[i] = cyc;
                    last_clr[i]  = !lcd_rs[i] && (lcd_data[i] == 8'h01 || lcd_data[i] == 8'h02);
                    if (i == 0) cap0.push_back({lcd_rs[i], lcd_data[i]});
                    else        cap1.push_back({lcd_rs[i], lcd_data[i]});
                end
                en_prev[i] = lcd_en[i];
            end
            d_prev[i]  = lcd_data[i];
            rs_prev[i] = lcd_rs[i];
        end
    end

    int rd[2] = '{0, 0};

    function automatic int cap_size(input int inst);
        return inst != 0 ? cap1.size() : cap0.size();
    endfunction

    function automatic logic [8:0] cap_at(input int inst, input int idx);
        return inst != 0 ? cap1[idx] : cap0[idx];
    endfunction

    // Display model: cursor position/validity and displayed characters per instance.
    int         cur_r[2];
    int         cur_c[2];
    bit         cur_v[2];
    logic [7:0] shd[2][160];
    logic [8:0] mexp[$];
    bit         merr;

    function automatic int n_rows(input int inst);
        return inst != 0 ? 4 : 2;
    endfunction

    function automatic int n_cols(input int inst);
        return inst != 0 ? 20 : 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cur_r[i] = 0; cur_c[i] = 0; cur_v[i] = 1'b1;
            for (int j = 0; j < 160; j++) shd[i][j] = 8'h20;
        end
    endtask

    task automatic model_req(input int inst, input bit clr, input int row, input int col, input logic [7:0] ch);
        int cols;
        int a;
        cols = n_cols(inst);
        mexp.delete();
        merr = 1'b0;
        if (clr) begin
            mexp.push_back(9'h001);
            cur_r[inst] = 0; cur_c[inst] = 0; cur_v[inst] = 1'b1;
            for (int j = 0; j < 160; j++) shd[inst][j] = 8'h20;
        end else if (row >= n_rows(inst) || col >= cols) begin
            merr = 1'b1;
        end else if (!(SHADOW && shd[inst][row * 40 + col] == ch)) begin
            if (!(cur_v[inst] && cur_r[inst] == row && cur_c[inst] == col)) begin
                a = col + ((row % 2 == 1) ? 'h40 : 0) + ((row >= 2) ? cols : 0);
                mexp.push_back(9'('h80 | a));
            end
            mexp.push_back({1'b1, ch});
            shd[inst][row * 40 + col] = ch;
            cur_r[inst] = row;
            cur_c[inst] = col + 1;
            cur_v[inst] = (col + 1) < cols;
        end
    endtask

    task automatic issue(input int inst, input bit clr, input int row, input int col, input logic [7:0] ch);
        model_req(inst, clr, row, col, ch);
        req_clr[inst]   = clr;
        req_row[inst]   = 2'(row);
        req_col[inst]   = 6'(col);
        req_char[inst]  = ch;
        req_valid[inst] = 1'b1;
    endtask

    // Wait for acceptance, scramble the fields, wait for ready, then compare bus bytes and err pulses.
    task automatic complete(input int inst, input string name, input bit use_hand, input int hn,
                            input logic [8:0] hb0, input logic [8:0] hb1, input bit herr, output int lat);
        logic [8:0] exp[$];
        int         n_err;
        int         n_got;
        bit         ok;
        n_err = 0;
        lat   = -1;
        ok    = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (req_ready[inst]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check_eq({name, "_accept"}, int'(ok), 1);
        if (ok) begin
            @(posedge clk);
            #1;
            req_valid[inst] = 1'b0;
            req_clr[inst]   = 1'($urandom);
            req_row[inst]   = 2'($urandom);
            req_col[inst]   = 6'($urandom);
            req_char[inst]  = 8'($urandom);
            ok = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (err_range[inst]) n_err++;
                if (req_ready[inst]) begin ok = 1'b1; lat = k + 1; break; end
            end
            check_eq({name, "_ready_back"}, int'(ok), 1);
        end else begin
            req_valid[inst] = 1'b0;
        end
        if (use_hand) begin
            if (hn > 0) exp.push_back(hb0);
            if (hn > 1) exp.push_back(hb1);
        end else begin
            exp = mexp;
            herr = merr;
        end
        n_got = cap_size(inst) - rd[inst];
        check_eq({name, "_n_bytes"}, n_got, exp.size());
        for (int i = 0; i < n_got && i < exp.size(); i++)
            check_eq({name, "_byte"}, int'(cap_at(inst, rd[inst] + i)), int'(exp[i]));
        rd[inst] += n_got;
        check_eq({name, "_err_pulses"}, n_err, herr ? 1 : 0);
    endtask

    logic [8:0] init_exp[4] = '{9'h038, 9'h00C, 9'h001, 9'h006};

    task automatic wait_init(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (init_done == 2'b11) begin ok = 1'b1; break; end
        end
        check_eq({name, "_init_done"}, int'(ok), 1);
        for (int i = 0; i < 2; i++) begin
            check_eq({name, "_init_n"}, cap_size(i) - rd[i], 4);
            for (int j = 0; j < 4 && rd[i] + j < cap_size(i); j++)
                check_eq({name, "_init_byte"}, int'(cap_at(i, rd[i] + j)), int'(init_exp[j]));
            rd[i] = cap_size(i);
            check_ge({name, "_power_wait"}, first_en[i], T_POWER);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            check_eq({name, "_data"}, int'(lcd_data[i]), 0);
            check_eq({name, "_rs_en"}, int'({lcd_rs[i], lcd_en[i]}), 0);
            check_eq({name, "_ready_done_err"}, int'({req_ready[i], init_done[i], err_range[i]}), 0);
            check_eq({name, "_ties"}, int'({lcd_rw[i], lcd_on[i], lcd_blon[i]}), 3);
        end
    endtask

    typedef struct {
        int         inst;
        bit         clr;
        int         row;
        int         col;
        logic [7:0] ch;
        int         n;
        logic [8:0] b0;
        logic [8:0] b1;
        bit         err;
    } vec_t;

    vec_t       tbl[13];
    logic [7:0] chars[4] = '{8'h41, 8'h42, 8'h43, 8'h20};

    initial begin
        int lat;
        int inst;
        int p;
        int row;
        int col;
        bit clr;
        bit found;

        tbl[0]  = '{0, 1'b0, 1, 4,  8'h42, 1, 9'h142, 9'h000, 1'b0};
        tbl[1]  = '{0, 1'b0, 2, 0,  8'h51, 0, 9'h000, 9'h000, 1'b1};
        tbl[2]  = '{0, 1'b1, 0, 0,  8'h00, 1, 9'h001, 9'h000, 1'b0};
        tbl[3]  = '{0, 1'b0, 0, 0,  8'h48, 1, 9'h148, 9'h000, 1'b0};
        tbl[4]  = '{0, 1'b0, 0, 15, 8'h45, 2, 9'h08F, 9'h145, 1'b0};
        tbl[5]  = '{0, 1'b0, 1, 0,  8'h46, 2, 9'h0C0, 9'h146, 1'b0};
        tbl[6]  = '{0, 1'b0, 0, 16, 8'h78, 0, 9'h000, 9'h000, 1'b1};
        tbl[7]  = '{0, 1'b0, 0, 0,  8'h5A, 2, 9'h080, 9'h15A, 1'b0};
        tbl[8]  = '{0, 1'b0, 0, 0,  8'h5A, SHADOW ? 0 : 2, 9'h080, 9'h15A, 1'b0};
        tbl[9]  = '{1, 1'b0, 2, 0,  8'h58, 2, 9'h094, 9'h158, 1'b0};
        tbl[10] = '{1, 1'b0, 3, 19, 8'h59, 2, 9'h0E7, 9'h159, 1'b0};
        tbl[11] = '{1, 1'b0, 0, 0,  8'h57, 2, 9'h080, 9'h157, 1'b0};
        tbl[12] = '{1, 1'b0, 3, 20, 8'h61, 0, 9'h000, 9'h000, 1'b1};

        req_valid = '0; req_clr = '0; req_row = '0; req_col = '0; req_char = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Request held pending through power-on wait and init.
        issue(0, 1'b0, 1, 3, 8'h41);
        @(negedge clk);
        reset_n = 1'b1;
        rel_cyc = cyc;
        wait_init("boot");
        complete(0, "held_write", 1'b1, 2, 9'h0C3, 9'h141, 1'b0, lat);

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].inst, tbl[i].clr, tbl[i].row, tbl[i].col, tbl[i].ch);
            complete(tbl[i].inst, $sformatf("vec%0d", i), 1'b1, tbl[i].n, tbl[i].b0, tbl[i].b1, tbl[i].err, lat);
            if (tbl[i].n == 0) check_eq($sformatf("vec%0d_quick_ready", i), lat, 2);
        end

        for (int r = 0; r < 80; r++) begin
            inst = r % 2;
            p    = $urandom_range(0, 15);
            clr  = (p == 0);
            if (p < 8 && cur_v[inst]) begin
                row = cur_r[inst];
                col = cur_c[inst];
            end else begin
                row = $urandom_range(0, 3);
                col = $urandom_range(0, n_cols(inst) + 2);
            end
            issue(inst, clr, row, col, chars[$urandom_range(0, 3)]);
            complete(inst, $sformatf("rnd%0d", r), 1'b0, 0, 9'h000, 9'h000, 1'b0, lat);
        end

        // Reset in the middle of an EN pulse, then full re-init.
        issue(1, 1'b0, 1, 5, 8'h4D);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (lcd_en[1]) begin found = 1'b1; break; end
        end
        check_eq("midop_en_seen", int'(found), 1);
        #2;
        reset_n = 1'b0;
        req_valid = '0;
        #1;
        check_reset_outputs("midop_reset");
        model_reset();
        repeat (3) @(negedge clk);
        rd[0] = cap_size(0);
        rd[1] = cap_size(1);
        reset_n = 1'b1;
        rel_cyc = cyc;
        wait_init("reinit");
        issue(1, 1'b0, 0, 0, 8'h4B);
        complete(1, "post_reinit", 1'b1, 1, 9'h14B, 9'h000, 1'b0, lat);

        check_eq("en_with_bus_change", viol_stable, 0);
        check_eq("en_width", viol_width, 0);
        check_eq("ready_before_init", viol_ready, 0);
        for (int i = 0; i < 2; i++) begin
            check_ge($sformatf("clear_gap%0d", i), min_gap_clr[i], T_EN + T_CLEAR + T_SETUP);
            check_ge($sformatf("exec_gap%0d", i), min_gap_norm[i], T_EN + T_EXEC + T_SETUP);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
